// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer:
// state encoding, instruction fields, ALU codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_HALT      = 4'd14
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  // R-type ALU operation; JR never reaches R_EXEC so anything unknown adds
  function automatic logic [3:0] rtype_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_retire(input mc_state_e state, input logic mem_ready);
    case (state)
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: return 1'b1;
      S_MEM_WRITE: return mem_ready;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of instruction fields, datapath status and control strobes between
// the sequencer (slave) and the datapath/memory side (master).
interface multicycle_control_if #(
  parameter int INSTR_CNT_W = 32
);
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic                   alu_zero;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   iord;
  logic                   mem_read;
  logic                   mem_write;
  logic                   ir_write;
  logic                   reg_write;
  logic [1:0]             reg_dst;
  logic [1:0]             wb_sel;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [3:0]             alu_ctl;
  logic [1:0]             pc_source;
  logic                   halt;
  logic [3:0]             state_o;
  logic [INSTR_CNT_W-1:0] instr_count;

  modport slave (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, wb_sel, alu_src_a, alu_src_b, alu_ctl, pc_source,
           halt, state_o, instr_count
  );

  modport master (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, wb_sel, alu_src_a, alu_src_b, alu_ctl, pc_source,
           halt, state_o, instr_count
  );
endinterface

// File: rtl/multicycle_control_next_state.sv
// Combinational next-state decode for the multi-cycle sequencer; memory
// states hold until mem_ready and DECODE dispatches on opcode/funct.
module mc_next_state
  import mc_pkg::*;
(
  input  mc_state_e  state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output mc_state_e  state_d_o
);

  always_comb begin
    state_d_o = state_i;
    case (state_i)
      S_FETCH:     state_d_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:     state_d_o = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct_i == FN_JR) begin
              state_d_o = S_JR;
            end else if (funct_i == FN_ADD || funct_i == FN_SUB || funct_i == FN_SLT) begin
              state_d_o = S_R_EXEC;
            end else begin
              state_d_o = S_HALT;
            end
          end
          OP_ADDI, OP_XORI: state_d_o = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d_o = S_BRANCH;
          OP_J:             state_d_o = S_JUMP;
          OP_JAL:           state_d_o = S_JAL;
          default:          state_d_o = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_d_o = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d_o = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d_o = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d_o = S_R_WB;
      S_I_EXEC:    state_d_o = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                   state_d_o = S_FETCH;
      S_HALT:      state_d_o = S_HALT;
      default:     state_d_o = S_HALT;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control sequencer: state register, Moore output decode of
// every datapath select/enable, and a retired-instruction counter.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int INSTR_CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  mc_state_e              state_q, state_d;
  logic [INSTR_CNT_W-1:0] instr_count_q;

  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, halt;
  logic [1:0] reg_dst, wb_sel, alu_src_b, pc_source;
  logic [3:0] alu_ctl;

  mc_next_state u_next_state (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .mem_ready_i (bus.mem_ready),
    .state_d_o   (state_d)
  );

  // Reset takes priority, so an instruction cut short never retires
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (is_retire(state_q, bus.mem_ready)) begin
        instr_count_q <= instr_count_q + INSTR_CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = REGDST_RT;
    wb_sel    = WB_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REGB;
    alu_ctl   = ALU_ADD;
    pc_source = PCSRC_ALU;
    halt      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        alu_src_b = SRCB_FOUR;
        pc_source = PCSRC_ALU;
      end
      // Speculative branch target computed while the opcode is decoded
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
        wb_sel    = WB_MDR;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_ctl   = rtype_alu(bus.funct);
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RD;
        wb_sel    = WB_ALUOUT;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = (bus.opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
        wb_sel    = WB_ALUOUT;
      end
      // Opcode bit 0 distinguishes BNE from BEQ
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_ctl   = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = bus.opcode[0] ? ~bus.alu_zero : bus.alu_zero;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      S_JAL: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        reg_dst   = REGDST_R31;
        wb_sel    = WB_PC;
      end
      S_JR: begin
        pc_source = PCSRC_REGA;
        pc_write  = 1'b1;
      end
      S_HALT:  halt = 1'b1;
      default: halt = 1'b1;
    endcase
  end

  assign bus.pc_write    = pc_write;
  assign bus.iord        = iord;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.ir_write    = ir_write;
  assign bus.reg_write   = reg_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.wb_sel      = wb_sel;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_ctl     = alu_ctl;
  assign bus.pc_source   = pc_source;
  assign bus.halt        = halt;
  assign bus.state_o     = state_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic [1:0] pc_source;
    logic       halt;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_count = 32'd0;

  multicycle_control_if #(.INSTR_CNT_W(32)) bus ();

  multicycle_control #(.INSTR_CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected control word for one cycle, straight from the per-state table
  function automatic ctl_t exp_ctl(input mc_state_e s, input logic [5:0] op,
                                   input logic [5:0] fn, input logic zero, input logic rdy);
    ctl_t c;
    c = '0;
    c.alu_ctl = 4'b0010;
    case (s)
      S_FETCH:     begin c.mem_read = 1; c.ir_write = rdy; c.pc_write = rdy; c.alu_src_b = 2'd1; end
      S_DECODE:    c.alu_src_b = 2'd3;
      S_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      S_MEM_READ:  begin c.iord = 1; c.mem_read = 1; end
      S_MEM_WB:    begin c.reg_write = 1; c.wb_sel = 2'd1; end
      S_MEM_WRITE: begin c.iord = 1; c.mem_write = 1; end
      S_R_EXEC: begin
        c.alu_src_a = 1;
        c.alu_ctl = (fn == 6'h22) ? 4'b0110 : (fn == 6'h2A) ? 4'b0111 : 4'b0010;
      end
      S_R_WB:      begin c.reg_write = 1; c.reg_dst = 2'd1; end
      S_I_EXEC: begin
        c.alu_src_a = 1; c.alu_src_b = 2'd2;
        c.alu_ctl = (op == 6'h0E) ? 4'b1101 : 4'b0010;
      end
      S_I_WB:      c.reg_write = 1;
      S_BRANCH: begin
        c.alu_src_a = 1; c.alu_ctl = 4'b0110; c.pc_source = 2'd1;
        c.pc_write = (op == 6'h05) ? !zero : zero;
      end
      S_JUMP:      begin c.pc_source = 2'd2; c.pc_write = 1; end
      S_JAL: begin
        c.pc_source = 2'd2; c.pc_write = 1; c.reg_write = 1; c.reg_dst = 2'd2; c.wb_sel = 2'd2;
      end
      S_JR:        begin c.pc_source = 2'd3; c.pc_write = 1; end
      default:     c.halt = 1;
    endcase
    return c;
  endfunction

  // Instruction-level model: state walk for one instruction, length = latency
  function automatic int plan(input logic [5:0] op, input logic [5:0] fn,
                              output mc_state_e seq [5]);
    for (int i = 0; i < 5; i++) seq[i] = S_FETCH;
    seq[1] = S_DECODE;
    if (op == 6'h23) begin seq[2] = S_MEM_ADDR; seq[3] = S_MEM_READ; seq[4] = S_MEM_WB; return 5; end
    if (op == 6'h2B) begin seq[2] = S_MEM_ADDR; seq[3] = S_MEM_WRITE; return 4; end
    if (op == 6'h00 && fn == 6'h08) begin seq[2] = S_JR; return 3; end
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      seq[2] = S_R_EXEC; seq[3] = S_R_WB; return 4;
    end
    if (op == 6'h08 || op == 6'h0E) begin seq[2] = S_I_EXEC; seq[3] = S_I_WB; return 4; end
    if (op == 6'h04 || op == 6'h05) begin seq[2] = S_BRANCH; return 3; end
    if (op == 6'h02) begin seq[2] = S_JUMP; return 3; end
    if (op == 6'h03) begin seq[2] = S_JAL; return 3; end
    seq[2] = S_HALT;
    return 3;
  endfunction

  function automatic ctl_t got_ctl();
    ctl_t c;
    c = '{bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
          bus.reg_dst, bus.wb_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_ctl, bus.pc_source,
          bus.halt};
    return c;
  endfunction

  task automatic drive_cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input logic rdy);
    @(negedge clk);
    reset         = rst;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.alu_zero  = zero;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    drive_cycle(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h23, 6'h00, 1'b0, 1'b1);
    model_count = 32'd0;
    total++;
    if (bus.state_o !== S_FETCH) begin
      bad++; $display("[TB] FAIL reset_state: got %0d expected %0d", bus.state_o, S_FETCH);
    end
    total++;
    if (got_ctl() !== exp_ctl(S_FETCH, 6'h23, 6'h00, 1'b0, 1'b1)) begin
      bad++; $display("[TB] FAIL reset_ctl: got %h expected %h", got_ctl(), exp_ctl(S_FETCH, 6'h23, 6'h00, 1'b0, 1'b1));
    end
    total++;
    if (bus.instr_count !== 32'd0 || bus.halt !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_count_halt: got count=%0d halt=%b expected 0/0", bus.instr_count, bus.halt);
    end
  endtask

  task automatic test_lw();
    mc_state_e seq [5];
    int n;
    n = plan(6'h23, 6'h00, seq);
    for (int k = 0; k < n; k++) begin
      if (k > 0) drive_cycle(1'b1, 6'h23, 6'h11, 1'b0, 1'b1);
      total++;
      if (bus.state_o !== seq[k] || got_ctl() !== exp_ctl(seq[k], 6'h23, 6'h11, 1'b0, 1'b1)) begin
        bad++; $display("[TB] FAIL lw_step%0d: got state=%0d ctl=%h expected state=%0d ctl=%h",
                        k, bus.state_o, got_ctl(), seq[k], exp_ctl(seq[k], 6'h23, 6'h11, 1'b0, 1'b1));
      end
    end
    total++;
    if (bus.reg_write !== 1'b1 || bus.wb_sel !== 2'd1 || bus.reg_dst !== 2'd0) begin
      bad++; $display("[TB] FAIL lw_wb: got rw=%b wb=%0d dst=%0d expected 1/1/0", bus.reg_write, bus.wb_sel, bus.reg_dst);
    end
    model_count++;
  endtask

  task automatic test_sw_wait();
    mc_state_e st [7] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WRITE, S_MEM_WRITE, S_MEM_WRITE, S_MEM_WRITE};
    logic      rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      drive_cycle(1'b1, 6'h2B, 6'h3C, 1'b1, rd[k]);
      total++;
      if (bus.state_o !== st[k] || got_ctl() !== exp_ctl(st[k], 6'h2B, 6'h3C, 1'b1, rd[k])) begin
        bad++; $display("[TB] FAIL sw_step%0d: got state=%0d ctl=%h expected state=%0d ctl=%h",
                        k, bus.state_o, got_ctl(), st[k], exp_ctl(st[k], 6'h2B, 6'h3C, 1'b1, rd[k]));
      end
      total++;
      if (bus.instr_count !== model_count) begin
        bad++; $display("[TB] FAIL sw_count%0d: got %0d expected %0d", k, bus.instr_count, model_count);
        model_count = bus.instr_count;
      end
    end
    model_count++;
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'h05, 6'h04, 6'h04};
    logic       zs  [3] = '{1'b0, 1'b0, 1'b1};
    logic       pcw [3] = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      drive_cycle(1'b1, ops[t], 6'h00, zs[t], 1'b1);
      total++;
      if (bus.instr_count !== model_count) begin
        bad++; $display("[TB] FAIL br_count%0d: got %0d expected %0d", t, bus.instr_count, model_count);
      end
      drive_cycle(1'b1, ops[t], 6'h00, zs[t], 1'b1);
      drive_cycle(1'b1, ops[t], 6'h00, zs[t], 1'b1);
      total++;
      if (bus.state_o !== S_BRANCH || bus.pc_write !== pcw[t] || bus.pc_source !== 2'd1) begin
        bad++; $display("[TB] FAIL branch%0d: got state=%0d pcw=%b src=%0d expected %0d/%b/1",
                        t, bus.state_o, bus.pc_write, bus.pc_source, S_BRANCH, pcw[t]);
      end
      model_count++;
    end
  endtask

  task automatic test_jal_jr();
    drive_cycle(1'b1, 6'h03, 6'h15, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h03, 6'h15, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h03, 6'h15, 1'b0, 1'b1);
    total++;
    if (bus.state_o !== S_JAL || bus.pc_write !== 1'b1 || bus.reg_write !== 1'b1 ||
        bus.reg_dst !== 2'd2 || bus.wb_sel !== 2'd2 || bus.pc_source !== 2'd2) begin
      bad++; $display("[TB] FAIL jal: got state=%0d ctl=%h expected state=%0d pcw=1 rw=1 dst=2 wb=2 src=2",
                      bus.state_o, got_ctl(), S_JAL);
    end
    model_count++;
    drive_cycle(1'b1, 6'h00, 6'h08, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h00, 6'h08, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h00, 6'h08, 1'b0, 1'b1);
    total++;
    if (bus.state_o !== S_JR || bus.pc_source !== 2'd3 || bus.pc_write !== 1'b1) begin
      bad++; $display("[TB] FAIL jr: got state=%0d src=%0d pcw=%b expected %0d/3/1",
                      bus.state_o, bus.pc_source, bus.pc_write, S_JR);
    end
    model_count++;
  endtask

  task automatic test_random();
    mc_state_e  seq [5];
    int         n, waits;
    logic [5:0] op, fn;
    logic       rdy, zero;
    ctl_t       e;
    for (int i = 0; i < 80; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 8))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin
          op = 6'h00;
          case ($urandom_range(0, 3))
            0: fn = 6'h08;
            1: fn = 6'h20;
            2: fn = 6'h22;
            default: fn = 6'h2A;
          endcase
        end
        3: op = 6'h08;
        4: op = 6'h0E;
        5: op = 6'h04;
        6: op = 6'h05;
        7: op = 6'h02;
        default: op = 6'h03;
      endcase
      n = plan(op, fn, seq);
      for (int k = 0; k < n; k++) begin
        waits = 0;
        for (int c = 0; c < 4; c++) begin
          rdy  = ($urandom_range(0, 2) != 0) || (waits >= 3);
          zero = 1'($urandom_range(0, 1));
          drive_cycle(1'b1, op, fn, zero, rdy);
          e = exp_ctl(seq[k], op, fn, zero, rdy);
          total++;
          if (bus.state_o !== seq[k]) begin
            bad++; $display("[TB] FAIL rand_state i=%0d k=%0d op=%h fn=%h: got %0d expected %0d",
                            i, k, op, fn, bus.state_o, seq[k]);
          end
          total++;
          if (got_ctl() !== e) begin
            bad++; $display("[TB] FAIL rand_ctl i=%0d k=%0d op=%h fn=%h: got %h expected %h",
                            i, k, op, fn, got_ctl(), e);
          end
          total++;
          if (bus.instr_count !== model_count) begin
            bad++; $display("[TB] FAIL rand_count i=%0d: got %0d expected %0d", i, bus.instr_count, model_count);
            model_count = bus.instr_count;
          end
          if (!(seq[k] inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) || rdy) break;
          waits++;
        end
      end
      model_count++;
    end
  endtask

  task automatic test_midreset();
    drive_cycle(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1);
    total++;
    if (bus.instr_count !== model_count) begin
      bad++; $display("[TB] FAIL mid_count_before: got %0d expected %0d", bus.instr_count, model_count);
    end
    drive_cycle(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1);
    drive_cycle(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1);
    total++;
    if (bus.state_o !== S_MEM_WRITE) begin
      bad++; $display("[TB] FAIL mid_state: got %0d expected %0d", bus.state_o, S_MEM_WRITE);
    end
    drive_cycle(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    model_count = 32'd0;
    total++;
    if (bus.state_o !== S_FETCH || bus.instr_count !== 32'd0 || bus.pc_write !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_after: got state=%0d count=%0d pcw=%b expected %0d/0/0",
                      bus.state_o, bus.instr_count, bus.pc_write, S_FETCH);
    end
  endtask

  task automatic test_halt();
    drive_cycle(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      drive_cycle(1'b1, 6'h3F, 6'($urandom), 1'($urandom), 1'($urandom));
      total++;
      if (bus.state_o !== S_HALT || got_ctl() !== exp_ctl(S_HALT, 6'h3F, 6'h00, 1'b0, 1'b0) ||
          bus.instr_count !== model_count) begin
        bad++; $display("[TB] FAIL halt%0d: got state=%0d ctl=%h count=%0d expected %0d/%h/%0d",
                        k, bus.state_o, got_ctl(), bus.instr_count, S_HALT,
                        exp_ctl(S_HALT, 6'h3F, 6'h00, 1'b0, 1'b0), model_count);
      end
    end
    drive_cycle(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    drive_cycle(1'b1, 6'h00, 6'h00, 1'b0, 1'b1);
    total++;
    if (bus.state_o !== S_FETCH || bus.halt !== 1'b0 || bus.mem_read !== 1'b1 || bus.instr_count !== 32'd0) begin
      bad++; $display("[TB] FAIL halt_exit: got state=%0d halt=%b mrd=%b count=%0d expected %0d/0/1/0",
                      bus.state_o, bus.halt, bus.mem_read, bus.instr_count, S_FETCH);
    end
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_jal_jr();
    test_random();
    test_midreset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer that replaces the per-instruction combinational control unit.
- Lets the CPU datapath share one ALU and one unified instruction/data memory across 3–5 cycles per instruction.
- Decodes opcode/funct from the instruction register and steps a state machine.
- Waits on a memory ready handshake and drives every datapath mux select and write enable.

Parameters:
- INSTR_CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- alu_zero  in  1  ALU zero flag (A-B compare in BRANCH)
- mem_ready  in  1  memory completed current read/write this cycle
- pc_write  out  1  load PC
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- reg_write  out  1  regfile write enable
- reg_dst  out  2  write register: 0 rt, 1 rd, 2 r31
- wb_sel  out  2  write data: 0 ALUOut, 1 MDR, 2 PC
- alu_src_a  out  1  0 PC, 1 regA
- alu_src_b  out  2  0 regB, 1 const 4, 2 imm32, 3 imm32<<2
- alu_ctl  out  4  ALU operation code
- pc_source  out  2  0 ALU result, 1 ALUOut, 2 {PC[31:28],addr,2'b00}, 3 regA
- halt  out  1  sticky, set on illegal instruction
- state_o  out  4  current state encoding (debug)
- instr_count  out  INSTR_CNT_W  retired-instruction count

Behaviour:
- Reset (reset==0 at posedge):
  - state=FETCH, instr_count=0, halt=0.
  - All outputs are Moore-decoded from state, so reset values are the FETCH values: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctl=ADD.
  - pc_write and ir_write are gated by mem_ready.
  - Reset mid-instruction abandons the instruction with no writes.
- Default for every unlisted output in a state: 0 (alu_ctl=ADD).
- States and transitions:
  - FETCH: mem_read=1, ir_write=mem_ready, pc_write=mem_ready, alu computes PC+4, pc_source=0. Stays until mem_ready; then goes to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_ctl=ADD (branch target into ALUOut). Next state by opcode:
    - 0x23/0x2B → MEM_ADDR
    - 0x00, funct 0x08 → JR
    - 0x00, funct 0x20/0x22/0x2A → R_EXEC
    - 0x08/0x0E → I_EXEC
    - 0x04/0x05 → BRANCH
    - 0x02 → JUMP
    - 0x03 → JAL
    - otherwise → HALT
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. LW → MEM_READ; SW → MEM_WRITE.
  - MEM_READ: iord=1, mem_read=1. Holds until mem_ready, then → MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, wb_sel=1. → FETCH.
  - MEM_WRITE: iord=1, mem_write=1. Holds until mem_ready, then → FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=0, alu_ctl from funct (ADD/SUB/SLT). → R_WB.
  - R_WB: reg_write=1, reg_dst=1, wb_sel=0. → FETCH.
  - I_EXEC: alu_src_a=1, alu_src_b=2, alu_ctl ADD (0x08) or XOR (0x0E). → I_WB.
  - I_WB: reg_write=1, reg_dst=0, wb_sel=0. → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1. pc_write=alu_zero for BEQ, ~alu_zero for BNE (opcode bit0 selects). → FETCH.
  - JUMP: pc_source=2, pc_write=1. → FETCH.
  - JAL: pc_source=2, pc_write=1, reg_write=1, reg_dst=2, wb_sel=2. PC already holds PC+4, so r31 gets the return address. → FETCH.
  - JR: pc_source=3, pc_write=1. → FETCH.
  - HALT: all enables 0, halt=1. Absorbing until reset.
- opcode/funct are sampled only in DECODE, R_EXEC, I_EXEC, MEM_ADDR and BRANCH. The instruction register is stable after FETCH.
- instr_count increments by 1 on the final-state exit of every retired instruction: MEM_WB, MEM_WRITE&mem_ready, R_WB, I_WB, BRANCH, JUMP, JAL, JR. It wraps modulo 2^INSTR_CNT_W and does not count HALT.
- mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- mem_read and mem_write are never both 1.
- Latency with zero-wait memory:
  - LW 5 cycles
  - SW/R-type/I-type 4 cycles
  - BEQ/BNE/J/JAL/JR 3 cycles

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit)
  - opcode/funct constants
  - alu_ctl constants: ADD 4'b0010, SUB 4'b0110, SLT 4'b0111, XOR 4'b1101
  - mux select constants for reg_dst, wb_sel, alu_src_b, pc_source
- One sub-module, mc_next_state: combinational next-state decode from state/opcode/funct/mem_ready.
- Output decode and counter stay in the top module.

Test Plan:
- Reset low 2 cycles, mem_ready=1 → state_o=FETCH, mem_read=1, instr_count=0, halt=0. First post-reset cycle asserts pc_write=ir_write=1.
- LW (opcode 0x23) with mem_ready=1 → state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. In MEM_WB: reg_write=1, wb_sel=1, reg_dst=0. instr_count=1.
- SW with mem_ready held 0 for 3 cycles in MEM_WRITE → mem_write=1 and iord=1 for 4 cycles. No state advance until mem_ready=1, then FETCH.
- BNE (0x05) with alu_zero=0 → pc_write=1, pc_source=1 in BRANCH. BEQ (0x04) with alu_zero=0 → pc_write=0.
- JAL (0x03) → single JAL cycle with pc_write=1, reg_write=1, reg_dst=2, wb_sel=2, pc_source=2. JR (0x00/0x08) → pc_source=3.
- Opcode 0x3F → HALT, halt=1, all enables 0 for 10+ cycles. reset=0 for 1 cycle returns to FETCH with halt=0.
